// File: rtl/ntt_result_drain.sv
// ntt_result_drain
// Captures one frame of P_LANES parallel NTT result lanes on a valid/ready
// handshake and drains it onto a P_OUT_LANES-wide bus over P_BEATS beats.
// A new frame can be accepted in the same cycle the last beat of the
// previous one is taken, so back-to-back frames stream without a bubble.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input frame handshake; in_data holds P_LANES lanes,
//                   lane 0 at the LSBs
//   out_valid/ready output beat handshake; out_data holds lanes
//                   out_beat*P_OUT_LANES upward, lowest lane at the LSBs
//   out_beat        index of the current beat
//   out_last        current beat is the final one of the frame
//   frame_cnt       frames fully drained, wraps modulo 2^P_CNT_W
module ntt_result_drain #(
    parameter int P_WIDTH     = 64,
    parameter int P_LANES     = 16,
    parameter int P_OUT_LANES = 4,
    parameter int P_CNT_W     = 16,
    localparam int P_BEATS    = P_LANES / P_OUT_LANES,
    localparam int BEAT_W     = (P_BEATS > 1) ? $clog2(P_BEATS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [P_LANES*P_WIDTH-1:0]     in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [P_OUT_LANES*P_WIDTH-1:0] out_data,
    output logic [BEAT_W-1:0]              out_beat,
    output logic                           out_last,
    output logic [P_CNT_W-1:0]             frame_cnt
);

    localparam int OUT_W = P_OUT_LANES * P_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P_BEATS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                     state_reg;
    logic [P_LANES*P_WIDTH-1:0] frame_reg;
    logic [BEAT_W-1:0]          beat_reg;
    logic [P_CNT_W-1:0]         frame_cnt_reg;

    logic [OUT_W-1:0] beat_data [P_BEATS];
    logic             is_last;
    logic             out_fire;
    logic             in_fire;

    // Fixed slices of the buffer, one per beat, so the output mux is a
    // plain array select indexed by the beat counter.
    generate
        for (genvar gi = 0; gi < P_BEATS; gi++) begin : g_beat
            assign beat_data[gi] = frame_reg[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign out_valid = (state_reg == DRAIN);
    assign is_last   = (beat_reg == LAST_BEAT);
    assign out_last  = out_valid & is_last;
    assign out_fire  = out_valid & out_ready;
    // The combinational path from out_ready lets the next frame load in the
    // cycle the last beat leaves, which is what keeps the stream gapless.
    assign in_ready  = (state_reg == IDLE) | (out_fire & is_last);
    assign in_fire   = in_valid & in_ready;
    assign out_data  = out_valid ? beat_data[beat_reg] : '0;
    assign out_beat  = beat_reg;
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_reg     <= '0;
            beat_reg      <= '0;
            frame_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        frame_reg <= in_data;
                        beat_reg  <= '0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (is_last) begin
                            frame_cnt_reg <= frame_cnt_reg + P_CNT_W'(1);
                            beat_reg      <= '0;
                            if (in_fire) begin
                                frame_reg <= in_data;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            beat_reg <= beat_reg + BEAT_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_result_drain.sv
// Directed testbench for ntt_result_drain. Two instances share stimulus:
// the default configuration and one with a 2-bit frame counter for wrap.
module tb_ntt_result_drain;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1023:0] in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [255:0]  out_data;
    logic [1:0]    out_beat;
    logic [15:0]   frame_cnt;
    logic          w_in_ready, w_out_valid, w_out_last;
    logic [255:0]  w_out_data;
    logic [1:0]    w_out_beat;
    logic [1:0]    w_frame_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int n_fire = 0;

    always #5 clk = ~clk;

    ntt_result_drain dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_beat(out_beat), .out_last(out_last),
        .frame_cnt(frame_cnt)
    );

    ntt_result_drain #(.P_CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_beat(w_out_beat), .out_last(w_out_last),
        .frame_cnt(w_frame_cnt)
    );

    always @(posedge clk) if (out_valid && out_ready) n_fire++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] mk_frame(input logic [63:0] base);
        logic [1023:0] r;
        for (int k = 0; k < 16; k++) r[k*64 +: 64] = base + 64'(k);
        return r;
    endfunction

    function automatic logic [255:0] mk_beat(input logic [63:0] base, input int b);
        logic [255:0] r;
        for (int k = 0; k < 4; k++) r[k*64 +: 64] = base + 64'(b*4 + k);
        return r;
    endfunction

    // Current negedge shows beat b of the frame starting at lane value base.
    task automatic expect_beat(input string tag, input logic [63:0] base, input int b);
        chk({tag, "_valid"}, 256'(out_valid), 256'(1));
        chk({tag, "_beat"}, 256'(out_beat), 256'(b));
        chk({tag, "_data"}, out_data, mk_beat(base, b));
        chk({tag, "_last"}, 256'(out_last), 256'(b == 3));
        $display("beat %s b=%0d data=%h last=%0d", tag, b, out_data, out_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Offer a frame while idle; returns at the negedge showing beat 0.
    task automatic capture(input string tag, input logic [63:0] base);
        in_valid = 1'b1; in_data = mk_frame(base);
        #1 chk({tag, "_cap_ready"}, 256'(in_ready), 256'(1));
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic drain(input string tag, input logic [63:0] base);
        for (int b = 0; b < 4; b++) begin
            out_ready = 1'b1;
            #1 expect_beat(tag, base, b);
            @(negedge clk);
        end
        #1 chk({tag, "_idle_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_idle_data"}, out_data, 256'(0));
        chk({tag, "_idle_ready"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_data", out_data, 256'(0));
        chk("rst_beat", 256'(out_beat), 256'(0));
        chk("rst_last", 256'(out_last), 256'(0));
        chk("rst_cnt", 256'(frame_cnt), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_ready", 256'(in_ready), 256'(1));
        @(negedge clk);

        // Single frame
        n_fire = 0;
        capture("single", 64'h1000);
        drain("single", 64'h1000);
        chk("single_cnt", 256'(frame_cnt), 256'(1));
        chk("single_fires", 256'(n_fire), 256'(4));

        // Backpressure during beat 1 with a competing frame offered
        do_reset();
        @(negedge clk);
        n_fire = 0;
        capture("bp", 64'h1000);
        out_ready = 1'b1;
        #1 expect_beat("bp", 64'h1000, 0);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            out_ready = 1'b0; in_valid = 1'b1; in_data = mk_frame(64'hF00);
            #1 expect_beat("bp_stall", 64'h1000, 1);
            chk("bp_stall_ready", 256'(in_ready), 256'(0));
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        for (int b = 1; b < 4; b++) begin
            out_ready = 1'b1;
            #1 expect_beat("bp", 64'h1000, b);
            @(negedge clk);
        end
        chk("bp_cnt", 256'(frame_cnt), 256'(1));
        chk("bp_fires", 256'(n_fire), 256'(4));
        chk("bp_idle", 256'(out_valid), 256'(0));

        // Back-to-back A then B, in_valid held high
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = mk_frame(64'hA00);
        @(negedge clk);
        in_data = mk_frame(64'hB00);
        for (int b = 0; b < 4; b++) begin
            #1 expect_beat("b2b_a", 64'hA00, b);
            chk("b2b_a_ready", 256'(in_ready), 256'(b == 3));
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        drain("b2b_b", 64'hB00);
        chk("b2b_cnt", 256'(frame_cnt), 256'(2));

        // Frame C offered during A's beat 1 is held off until A's last beat
        do_reset();
        @(negedge clk);
        capture("blk_a", 64'hA00);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                in_valid = 1'b1; in_data = mk_frame(64'hC00);
            end
            #1 expect_beat("blk_a", 64'hA00, b);
            chk("blk_a_ready", 256'(in_ready), 256'(b == 3));
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        drain("blk_c", 64'hC00);
        chk("blk_cnt", 256'(frame_cnt), 256'(2));

        // Asynchronous reset during beat 2 of the second frame
        do_reset();
        @(negedge clk);
        capture("mid1", 64'h1000);
        drain("mid1", 64'h1000);
        capture("mid2", 64'h2000);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 expect_beat("mid2", 64'h2000, 2);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_data", out_data, 256'(0));
        chk("mid_rst_cnt", 256'(frame_cnt), 256'(0));
        chk("mid_rst_beat", 256'(out_beat), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rel_ready", 256'(in_ready), 256'(1));
        chk("mid_rel_valid", 256'(out_valid), 256'(0));

        // Counter wrap on the 2-bit instance
        do_reset();
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            capture("wrap", 64'h3000 + 64'(f*16));
            drain("wrap", 64'h3000 + 64'(f*16));
            chk("wrap_cnt2", 256'(w_frame_cnt), 256'((f + 1) % 4));
            chk("wrap_cnt16", 256'(frame_cnt), 256'(f + 1));
            $display("frame %0d cnt2=%0d cnt16=%0d", f, w_frame_cnt, frame_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
